// File: rtl/pru_cmd_queue.sv
// PRU command queue: assembles two bus words into a draw command, buffers them in a FIFO, and dispatches to the PRU.
// The optional PRU_CMD_CLIP_EN macro clips rectangle width/height at push time.
module pru_cmd_queue #(
  parameter int COL_W   = 9,
  parameter int ROW_W   = 10,
  parameter int DEPTH   = 4,
  parameter int ROW_MAX = 640,
  parameter int COL_MAX = 480
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic [31:0]                wr_data,
  output logic                       wr_ack,
  input  logic                       flush,
  input  logic                       pru_ready,
  output logic                       start,
  output logic [1:0]                 color,
  output logic [ROW_W-1:0]           row,
  output logic [COL_W-1:0]           col,
  output logic [ROW_W-1:0]           width,
  output logic [COL_W-1:0]           height_radius,
  output logic [1:0]                 shape_select,
  output logic                       subtract,
  output logic                       color_load,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       half
);

  localparam int C  = COL_W;
  localparam int R  = ROW_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = C + R + 4;
  localparam logic [31:0] W_USED = (32'h1 << SW) - 32'h1;

  typedef struct packed {
    logic [1:0]   color;
    logic [R-1:0] row;
    logic [C-1:0] col;
    logic [R-1:0] width;
    logic [C-1:0] hr;
    logic [1:0]   shape;
    logic         sub;
    logic         cl;
  } cmd_t;

  typedef enum logic {
    S_IDLE,
    S_HALF
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_stage;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  cmd_t            r_mem [DEPTH];

  logic            w_full;
  logic            w_ok;
  logic            w_push;
  logic            w_pop;
  cmd_t            w_raw;
  cmd_t            w_cmd;
  cmd_t            w_head;
  logic            w_unused;

  // Upper bus bits carry nothing for this block.
  assign w_unused = ^(wr_data & ~W_USED);

  assign w_full = (r_count == CW'(DEPTH));
  assign w_ok   = wr && ((r_state == S_IDLE) || !w_full);
  assign wr_ack = rst_n && !flush && w_ok;
  assign w_push = wr_ack && (r_state == S_HALF);
  assign w_pop  = !flush && (r_count != '0)
                  && pru_ready && !start;

  assign half   = (r_state == S_HALF);
  assign count  = r_count;
  assign w_head = r_mem[r_rd_ptr];

  // Raw command from the staged word 0 and the incoming word 1.
  always_comb begin
    w_raw       = '0;
    w_raw.col   = r_stage[C-1:0];
    w_raw.row   = r_stage[C+R-1:C];
    w_raw.color = r_stage[C+R+1:C+R];
    w_raw.shape = r_stage[C+R+3:C+R+2];
    w_raw.hr    = wr_data[C-1:0];
    w_raw.width = wr_data[C+R-1:C];
    w_raw.sub   = wr_data[C+R+2];
    w_raw.cl    = wr_data[C+R+3];
  end

`ifdef PRU_CMD_CLIP_EN
  logic [R:0] w_row_rem;
  logic [C:0] w_col_rem;
  logic       w_row_out;
  logic       w_col_out;

  assign w_row_out = ({1'b0, w_raw.row} >= (R+1)'(ROW_MAX));
  assign w_col_out = ({1'b0, w_raw.col} >= (C+1)'(COL_MAX));
  assign w_row_rem = (R+1)'(ROW_MAX) - {1'b0, w_raw.row};
  assign w_col_rem = (C+1)'(COL_MAX) - {1'b0, w_raw.col};

  // Rectangles are clipped to the screen; circles pass through.
  always_comb begin
    w_cmd = w_raw;
    if (w_raw.shape == 2'b00) begin
      if (w_row_out)
        w_cmd.width = '0;
      else if ({1'b0, w_raw.width} > w_row_rem)
        w_cmd.width = w_row_rem[R-1:0];
      if (w_col_out)
        w_cmd.hr = '0;
      else if ({1'b0, w_raw.hr} > w_col_rem)
        w_cmd.hr = w_col_rem[C-1:0];
    end
  end
`else
  logic w_unused_clip;

  assign w_unused_clip = (ROW_MAX > 0) ^ (COL_MAX > 0);

  // Commands are stored exactly as received.
  always_comb begin
    w_cmd = w_raw;
  end
`endif

  // Assembly FSM: stage word 0, commit on word 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stage <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_stage <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (wr_ack) begin
            r_stage <= wr_data[SW-1:0];
            r_state <= S_HALF;
          end
        end
        S_HALF: begin
          if (wr_ack)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Command storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_cmd;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Dispatch: latch head fields and pulse start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start         <= 1'b0;
      color         <= '0;
      row           <= '0;
      col           <= '0;
      width         <= '0;
      height_radius <= '0;
      shape_select  <= '0;
      subtract      <= 1'b0;
      color_load    <= 1'b0;
    end else begin
      start <= w_pop;
      if (w_pop) begin
        color         <= w_head.color;
        row           <= w_head.row;
        col           <= w_head.col;
        width         <= w_head.width;
        height_radius <= w_head.hr;
        shape_select  <= w_head.shape;
        subtract      <= w_head.sub;
        color_load    <= w_head.cl;
      end
    end
  end

endmodule

// File: tb/tb_pru_cmd_queue.sv
// Bench for pru_cmd_queue: directed scenarios plus random traffic.
// A queue-based reference model predicts every output each cycle.
module tb_pru_cmd_queue;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic        flush = 1'b0;
  logic        pru_ready = 1'b0;
  logic        start;
  logic [1:0]  color;
  logic [9:0]  row;
  logic [8:0]  col;
  logic [9:0]  width;
  logic [8:0]  height_radius;
  logic [1:0]  shape_select;
  logic        subtract;
  logic        color_load;
  logic [2:0]  count;
  logic        half;

  pru_cmd_queue #(
    .COL_W(9), .ROW_W(10), .DEPTH(D),
    .ROW_MAX(640), .COL_MAX(480)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr(wr), .wr_data(wr_data), .wr_ack(wr_ack),
    .flush(flush), .pru_ready(pru_ready),
    .start(start), .color(color), .row(row),
    .col(col), .width(width),
    .height_radius(height_radius),
    .shape_select(shape_select),
    .subtract(subtract), .color_load(color_load),
    .count(count), .half(half)
  );

  always #5 clk = ~clk;

  typedef struct {
    int col, row, color, shape;
    int h, w, sub, cl;
  } cmd_t;

  cmd_t        q[$];
  cmd_t        cur;
  bit          m_half;
  bit          m_start;
  int unsigned m_stage;
  bit          last_ack;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_starts = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic cmd_t decode(int unsigned w0,
                                  int unsigned w1);
    cmd_t c;
    c.col   = int'(w0 % 512);
    c.row   = int'((w0 / 512) % 1024);
    c.color = int'((w0 >> 19) % 4);
    c.shape = int'((w0 >> 21) % 4);
    c.h     = int'(w1 % 512);
    c.w     = int'((w1 / 512) % 1024);
    c.sub   = int'((w1 >> 21) % 2);
    c.cl    = int'((w1 >> 22) % 2);
`ifdef PRU_CMD_CLIP_EN
    if (c.shape == 0) begin
      c.w = (c.row >= 640) ? 0 : min2(c.w, 640 - c.row);
      c.h = (c.col >= 480) ? 0 : min2(c.h, 480 - c.col);
    end
`endif
    return c;
  endfunction

  function automatic logic [63:0] pk(cmd_t c);
    return (longint'(c.color) << 42) |
           (longint'(c.row) << 32) |
           (longint'(c.col) << 23) |
           (longint'(c.w) << 13) |
           (longint'(c.h) << 4) |
           (longint'(c.shape) << 2) |
           (longint'(c.sub) << 1) |
           longint'(c.cl);
  endfunction

  function automatic logic [63:0] dut_fields();
    return {20'd0, color, row, col, width,
            height_radius, shape_select,
            subtract, color_load};
  endfunction

  task automatic model_reset();
    q.delete();
    cur = '{default: 0};
    m_half = 0;
    m_start = 0;
    m_stage = 0;
  endtask

  // One clock with full comparison of every output.
  task automatic cyc(bit iwr, int unsigned d,
                     bit rdy, bit fl);
    bit ack, pop;
    @(negedge clk);
    wr = iwr;
    wr_data = d;
    pru_ready = rdy;
    flush = fl;
    #1;
    ack = !fl && iwr && (!m_half || q.size() < D);
    check("wr_ack", wr_ack, ack);
    last_ack = ack;
    pop = !fl && q.size() != 0 && rdy && !m_start;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_half = 0;
      m_start = 0;
    end else begin
      if (pop) cur = q.pop_front();
      m_start = pop;
      if (ack) begin
        if (m_half) begin
          q.push_back(decode(m_stage, d));
          m_half = 0;
        end else begin
          m_stage = d;
          m_half = 1;
        end
      end
    end
    #1;
    if (start) n_starts++;
    check("start", start, m_start);
    check("count", count, q.size());
    check("half", half, m_half);
    check("fields", dut_fields(), pk(cur));
  endtask

  // Hold a word on the bus until it is accepted.
  task automatic hold(int unsigned d, bit rdy);
    for (int i = 0; i < 40; i++) begin
      cyc(1, d, rdy, 0);
      if (last_ack) return;
    end
    check("hold_timeout", 0, 1);
  endtask

  task automatic send(int unsigned w0, int unsigned w1,
                      bit rdy);
    hold(w0, rdy);
    hold(w1, rdy);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, rdy, 0);
  endtask

  int unsigned w0c, w1c;
  int          s0;

  initial begin
    model_reset();
    wr = 1'b1;
    #1;
    check("rst_ack", wr_ack, 0);
    check("rst_start", start, 0);
    check("rst_count", count, 0);
    check("rst_half", half, 0);
    check("rst_fields", dut_fields(), 0);
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single command, latency and decoded fields.
    hold(32'h0000_1205, 1);
    hold(32'h0040_0C10, 1);
    cyc(0, 0, 1, 0);
    check("lat_start", start, 1);
    check("lat_col", col, 5);
    check("lat_row", row, 9);
    check("lat_width", width, 6);
    check("lat_h", height_radius, 16);
    check("lat_cl", color_load, 1);
    idle(3, 1);

    // Fill to DEPTH with the engine busy.
    for (int i = 0; i < 4; i++)
      send(32'h100 + i, 32'h200 * (i + 1), 0);
    check("full_count", count, 4);
    hold(32'h0000_0777, 0);
    cyc(1, 32'h0000_0abc, 0, 0);
    check("full_ack", wr_ack, 0);
    check("full_half", half, 1);
    s0 = n_starts;
    hold(32'h0000_0abc, 1);
    idle(12, 1);
    check("drain_starts", n_starts - s0, 5);

    // Push and pop on the same edge at count 2.
    send(32'h11, 32'h21, 0);
    send(32'h12, 32'h22, 0);
    hold(32'h13, 0);
    cyc(1, 32'h23, 1, 0);
    check("pp_count", count, 2);
    idle(10, 1);

    // Flush while half a command is staged.
    for (int i = 0; i < 3; i++)
      send(32'h40 + i, 32'h50 + i, 0);
    hold(32'h99, 0);
    cyc(0, 0, 1, 1);
    check("fl_count", count, 0);
    check("fl_half", half, 0);
    s0 = n_starts;
    idle(4, 1);
    check("fl_nostart", n_starts - s0, 0);
    send(32'h0000_0033, 32'h0000_0044, 1);
    idle(3, 1);
    check("fl_col", col, 9'h33);

    // Clipping of rectangles; circles untouched.
    w0c = 470 | (600 << 9);
    w1c = 50 | (100 << 9);
    send(w0c, w1c, 1);
    cyc(0, 0, 1, 0);
`ifdef PRU_CMD_CLIP_EN
    check("clip_w", width, 40);
    check("clip_h", height_radius, 10);
`else
    check("noclip_w", width, 100);
    check("noclip_h", height_radius, 50);
`endif
    idle(2, 1);
    send(w0c | (1 << 21), w1c, 1);
    cyc(0, 0, 1, 0);
    check("circ_w", width, 100);
    check("circ_h", height_radius, 50);
    idle(2, 1);

    // Reset while start is high.
    send(32'h0000_1205, 32'h0040_0C10, 0);
    send(32'h0000_1205, 32'h0040_0C10, 0);
    for (int i = 0; i < 10 && !m_start; i++)
      cyc(0, 0, 1, 0);
    check("pre_rst_start", start, 1);
    rst_n = 1'b0;
    #1;
    check("arst_start", start, 0);
    check("arst_count", count, 0);
    check("arst_fields", dut_fields(), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, $urandom,
          ((i / 200) % 2 == 0) ? ($urandom % 4 == 0)
                               : ($urandom % 3 != 0),
          ($urandom % 80) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
